// File: rtl/bus_capture_arbiter_pkg.sv
// rtl/bus_capture_arbiter_pkg.sv - shared types and helpers for the capture-bus arbiter
package bus_capture_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Saturation ceiling for a counter of the given width (width up to 64)
  function automatic logic [63:0] cnt_max(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_capture_arbiter_if.sv
// rtl/bus_capture_arbiter_if.sv - requester and downstream signals of the capture-bus arbiter
interface bus_capture_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*DATA_W-1:0] DATA;
  logic [NUM_REQ-1:0]        GNT;
  logic                      Z_VALID;
  logic                      Z_READY;
  logic [DATA_W-1:0]         Z_DATA;
  logic [ID_W-1:0]           Z_ID;
  logic [CNT_W-1:0]          XFER_CNT;

  modport master (
    input  REQ, DATA, Z_READY,
    output GNT, Z_VALID, Z_DATA, Z_ID, XFER_CNT
  );

  modport slave (
    output REQ, DATA, Z_READY,
    input  GNT, Z_VALID, Z_DATA, Z_ID, XFER_CNT
  );
endinterface

// File: rtl/bus_capture_arbiter_rr_pick.sv
// rtl/bus_capture_arbiter_rr_pick.sv - combinational round-robin pick starting at a pointer
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin
    logic found;
    int   j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_capture_arbiter.sv
// rtl/bus_capture_arbiter.sv - round-robin capture of one requester word into a single-entry output register
module bus_capture_arbiter
  import bus_capture_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input logic CLK,
  input logic RST,
  bus_capture_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   z_data_q, z_data_d;
  logic [ID_W-1:0]     z_id_q, z_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                slot_free;
  logic                grant_en;
  logic                accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i (bus.REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Backpressure in FULL stalls every requester; Z_READY only reaches GNT
  assign slot_free = (state_q == ST_EMPTY) || bus.Z_READY;
  assign grant_en  = slot_free && (|bus.REQ) && !RST;
  assign accept    = (state_q == ST_FULL) && bus.Z_READY;
  assign bus.GNT   = grant_en ? pick_gnt : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    z_data_d = z_data_q;
    z_id_d   = z_id_q;
    cnt_d    = cnt_q;
    if (accept && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (grant_en) begin
      state_d  = ST_FULL;
      z_data_d = bus.DATA[int'(pick_idx)*DATA_W +: DATA_W];
      z_id_d   = pick_idx;
      ptr_d    = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + ID_W'(1);
    end else if (accept) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      z_data_q <= '0;
      z_id_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      z_data_q <= z_data_d;
      z_id_q   <= z_id_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.Z_VALID  = (state_q == ST_FULL);
  assign bus.Z_DATA   = z_data_q;
  assign bus.Z_ID     = z_id_q;
  assign bus.XFER_CNT = cnt_q;

endmodule

// File: doc/bus_capture_arbiter.md
Name: bus_capture_arbiter

Overview:
- Round-robin scheduler that shares one registered capture bus (CLK-sampled register bank) between NUM_REQ requesters.
- Selects one pending requester per free slot and latches its data word and index into a single-entry output register.
- Presents the word downstream with a valid/ready handshake.
- Sits between the cell-level register datapath and its multiple producers in the prsim/VPI co-simulation test designs.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, data word width
ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)), minimum 1
CNT_W, 16, width of transfer counter

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  reset; synchronous, active-high
REQ  input  NUM_REQ  per-requester request; held high until granted
DATA  input  NUM_REQ*DATA_W  requester i word at DATA[i*DATA_W +: DATA_W]; stable while REQ[i]=1
GNT  output  NUM_REQ  one-hot, combinational; GNT[i]=1 means requester i's word is captured at this posedge
Z_VALID  output  1  output register holds a word
Z_READY  input  1  downstream accepts the word when Z_VALID & Z_READY at posedge
Z_DATA  output  DATA_W  captured word
Z_ID  output  ID_W  index of requester that supplied Z_DATA
XFER_CNT  output  CNT_W  saturating count of completed downstream transfers

Behaviour:
- Reset (RST=1 at posedge):
  - Z_VALID=0, Z_DATA=0, Z_ID=0, XFER_CNT=0, PTR=0, state=EMPTY.
  - GNT forced to 0 while RST=1.
  - RST mid-transfer discards the held word; no GNT is issued in a reset cycle.
- State machine, two states:
  - EMPTY: Z_VALID=0.
  - FULL: Z_VALID=1.
- Slot free (SLOT_FREE) when state=EMPTY, or state=FULL and Z_READY=1.
- Arbitration (combinational):
  - When SLOT_FREE and |REQ, pick the first i with REQ[i]=1, scanning PTR, PTR+1, ..., wrapping mod NUM_REQ. Assert GNT[i]=1.
  - Otherwise GNT=0.
  - GNT is always 0 or one-hot.
- On a posedge with GNT[i]=1:
  - Z_DATA <= DATA word i.
  - Z_ID <= i.
  - state <= FULL.
  - PTR <= (i+1) mod NUM_REQ.
- On a posedge with state=FULL, Z_READY=1 and no GNT: state <= EMPTY; Z_DATA and Z_ID keep their values.
- State=FULL and Z_READY=0: hold everything; GNT=0 (backpressure stalls all requesters).
- PTR changes only on a grant. Requester PTR has highest priority next, which gives starvation-freedom: every requester is granted within NUM_REQ grants.
- Latency:
  - REQ[i] high in an EMPTY cycle n gives GNT[i]=1 in cycle n and Z_VALID=1 from cycle n+1.
  - Sustained throughput is 1 word/cycle with Z_READY tied high.
- Simultaneous accept and capture (FULL, Z_READY=1, REQ pending): the old word completes, the new word is loaded on the same edge, and Z_VALID stays 1.
- XFER_CNT increments by 1 on each posedge with Z_VALID & Z_READY. It saturates at 2^CNT_W-1 and never wraps.
- A requester dropping REQ before grant is legal: it is simply not selected. DATA of non-granted requesters is ignored.
- No combinational path from Z_READY to Z_VALID, Z_DATA or Z_ID. A combinational path from Z_READY to GNT is permitted.

Decomposition:
- Shared package contents:
  - State encoding constants (ST_EMPTY, ST_FULL).
  - Counter saturation helper constant.
  - ID_W derivation function (clog2).
- One sub-module, rr_pick:
  - Purely combinational.
  - Inputs: REQ vector, PTR.
  - Outputs: one-hot grant and binary index.
  - Reusable by other arbiters in the codebase.
- The parent owns the FSM, output register, PTR and counter.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=4'b1111 -> GNT=0, Z_VALID=0, Z_DATA=0, XFER_CNT=0; first cycle after reset, GNT=4'b0001.
- Round-robin fairness: REQ=4'b1111 held, DATA words 0xA0..0xA3, Z_READY=1 -> Z_ID sequence 0,1,2,3,0,1 with matching Z_DATA, one per cycle, XFER_CNT=6 after 7 cycles.
- Backpressure: capture 0xDEADBEEF from requester 2, hold Z_READY=0 for 5 cycles with REQ=4'b1011 -> Z_VALID, Z_DATA, Z_ID stable, GNT=0 throughout; on Z_READY=1 GNT=4'b1000 (PTR=3) the same cycle.
- Wrap and sparse requests: after a grant to requester 3, REQ=4'b0100 -> GNT=4'b0100, next PTR=3; then REQ=4'b0001 -> GNT=4'b0001.
- Drain: single request from requester 1, then REQ=0, Z_READY=1 -> Z_VALID high for exactly 1 cycle, then 0 with Z_DATA retained.
- Mid-operation reset and saturation: RST pulse while FULL -> Z_VALID=0 next cycle, PTR=0; with CNT_W=4, 20 transfers -> XFER_CNT=15.
